// File: rtl/prog_loader_pkg.sv
// ============================================================================
// prog_loader_pkg
// Shared definitions for the program loader: the loader state encoding, the
// eight Brainfuck opcode byte values used by the optional opcode filter, and
// the default terminator byte that ends a load.
// Optional feature macro: PROG_LOADER_FILTER_EN (see prog_loader.sv).
// No ports (package).
// ============================================================================
package prog_loader_pkg;

   // Loader states: idle after reset, streaming bytes, writing the 0x00
   // terminator, and holding the final length/overflow report.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      TERM = 2'd2,
      DONE = 2'd3
   } state_t;

   // Brainfuck opcode bytes: + - < > [ ] . ,
   localparam logic [7:0] OP_INC        = 8'h2B;
   localparam logic [7:0] OP_DEC        = 8'h2D;
   localparam logic [7:0] OP_LEFT       = 8'h3C;
   localparam logic [7:0] OP_RIGHT      = 8'h3E;
   localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;
   localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;
   localparam logic [7:0] OP_OUT        = 8'h2E;
   localparam logic [7:0] OP_IN         = 8'h2C;

   // '!' ends a load and is never stored itself.
   localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h21;

endpackage

// File: rtl/bf_opcode_filter.sv
// ============================================================================
// bf_opcode_filter
// Combinational classifier: flags whether an incoming byte is one of the eight
// Brainfuck opcodes. Only compiled and used when PROG_LOADER_FILTER_EN is
// defined; in the default build this file contributes nothing.
// Ports:
//   data       in   DATA_WIDTH  byte to classify
//   is_opcode  out  1           high when data is one of + - < > [ ] . ,
// ============================================================================
`ifdef PROG_LOADER_FILTER_EN
module bf_opcode_filter
   import prog_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  is_opcode
);

   // Direct compare against each opcode, widened to the data width so any
   // upper bits must be zero for a match.
   always_comb begin
      is_opcode = (data == DATA_WIDTH'(OP_INC))        ||
                  (data == DATA_WIDTH'(OP_DEC))        ||
                  (data == DATA_WIDTH'(OP_LEFT))       ||
                  (data == DATA_WIDTH'(OP_RIGHT))      ||
                  (data == DATA_WIDTH'(OP_LOOP_OPEN))  ||
                  (data == DATA_WIDTH'(OP_LOOP_CLOSE)) ||
                  (data == DATA_WIDTH'(OP_OUT))        ||
                  (data == DATA_WIDTH'(OP_IN));
   end

endmodule
`endif

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader
// Writer side of the program-memory port. Takes a byte stream (e.g. from a
// UART receiver) and writes it into program RAM at addresses 0,1,2,...
// A TERM_CHAR byte ends the load; a 0x00 terminator is then written at the
// next free address, and the program length and overflow status are reported.
// The top RAM word (NUM_WORDS-1) is reserved for that terminator.
//
// Optional feature macro: PROG_LOADER_FILTER_EN
//   defined     : accepted bytes that are not Brainfuck opcodes (and not
//                 TERM_CHAR) are consumed but neither written nor counted.
//   not defined : every non-TERM_CHAR byte is written verbatim.
//
// Ports:
//   clk       in   1           clock, rising edge
//   rst_n     in   1           synchronous active-low reset
//   start     in   1           pulse: begin a new load (only from IDLE/DONE)
//   in_valid  in   1           in_data holds a byte
//   in_ready  out  1           byte accepted when in_valid & in_ready
//   in_data   in   DATA_WIDTH  incoming program byte
//   wen       out  1           RAM write enable (one pulse per write)
//   waddr     out  ADDR_WIDTH  RAM write address
//   wdata     out  DATA_WIDTH  RAM write data
//   busy      out  1           high in LOAD and TERM
//   done      out  1           high in DONE until next start or reset
//   prog_len  out  ADDR_WIDTH  bytes stored, excluding the terminator
//   overflow  out  1           sticky: program too long; cleared by start
// ============================================================================
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    NUM_WORDS  = 256,
   parameter logic [DATA_WIDTH-1:0] TERM_CHAR  = DATA_WIDTH'(TERM_CHAR_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] prog_len,
   output logic                  overflow
);

   // Last RAM address; reserved for the terminator, so a program byte that
   // arrives while the counter sits here means the program is too long.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  accept;
   logic                  is_opcode;

`ifdef PROG_LOADER_FILTER_EN
   bf_opcode_filter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_filter (
      .data      (in_data),
      .is_opcode (is_opcode)
   );
`else
   assign is_opcode = 1'b1;
`endif

   // Ready depends on state only, so the upstream source never sees a
   // combinational path from its own valid back to ready.
   assign in_ready = (state == LOAD);
   assign accept   = in_valid && in_ready;

   // Single state machine with all outputs registered. A stored byte is
   // written one cycle after its handshake; the terminator write is issued on
   // entry to TERM so wen/waddr/wdata are valid during the TERM cycle itself.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr     <= '0;
         wen      <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         prog_len <= '0;
         overflow <= 1'b0;
      end else begin
         wen <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= LOAD;
                  addr     <= '0;
                  prog_len <= '0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (in_data == TERM_CHAR) begin
                     state    <= TERM;
                     wen      <= 1'b1;
                     waddr    <= addr;
                     wdata    <= '0;
                     prog_len <= addr;
                  end else if (is_opcode) begin
                     // Filtered-out bytes fall through here: consumed, but
                     // they neither write nor use up capacity.
                     if (addr == LAST_ADDR) begin
                        overflow <= 1'b1;
                        state    <= TERM;
                        wen      <= 1'b1;
                        waddr    <= addr;
                        wdata    <= '0;
                        prog_len <= addr;
                     end else begin
                        wen   <= 1'b1;
                        waddr <= addr;
                        wdata <= in_data;
                        addr  <= addr + ADDR_WIDTH'(1);
                     end
                  end
               end
            end
            TERM: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader
// Self-checking bench for prog_loader. Two instances share all inputs: one at
// the default depth (256 words) and one with NUM_WORDS=4 so the capacity
// boundary is reachable with short streams. Every RAM write of each instance
// is logged and compared against hand-written expected byte strings.
// Honours PROG_LOADER_FILTER_EN for the mixed-character load expectations.
// ============================================================================
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       big_ready, big_wen, big_busy, big_done, big_overflow;
   logic [7:0] big_waddr, big_wdata, big_prog_len;
   logic       small_ready, small_wen, small_busy, small_done, small_overflow;
   logic [7:0] small_waddr, small_wdata, small_prog_len;

   prog_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (big_ready),
      .in_data  (in_data),
      .wen      (big_wen),
      .waddr    (big_waddr),
      .wdata    (big_wdata),
      .busy     (big_busy),
      .done     (big_done),
      .prog_len (big_prog_len),
      .overflow (big_overflow)
   );

   prog_loader #(.NUM_WORDS(4)) dut_small (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (small_ready),
      .in_data  (in_data),
      .wen      (small_wen),
      .waddr    (small_waddr),
      .wdata    (small_wdata),
      .busy     (small_busy),
      .done     (small_done),
      .prog_len (small_prog_len),
      .overflow (small_overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [15:0] big_log[$];
   logic [15:0] small_log[$];

   bit   timing_on = 1'b0;
   logic exp_wen_next = 1'b0;
   int   timing_errs = 0;
   int   wen_count = 0;
   int   hs_count = 0;

   // Log every write of both instances, and while timing_on is set check that
   // the big instance writes exactly one cycle after each non-'!' handshake.
   always @(negedge clk) begin
      if (big_wen) big_log.push_back({big_waddr, big_wdata});
      if (small_wen) small_log.push_back({small_waddr, small_wdata});
      if (timing_on) begin
         if (big_wen !== exp_wen_next) timing_errs++;
         if (big_wen) wen_count++;
      end
      exp_wen_next = in_valid && big_ready && (in_data != 8'h21);
      if (timing_on && exp_wen_next) hs_count++;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Present one byte and hold it until the big instance takes it.
   task automatic applyStimulus(input logic [7:0] b);
      bit got = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (big_ready) got = 1'b1;
      end
      if (got) begin
         @(posedge clk);
         #1;
      end else begin
         checkOutput("handshake_timeout", 32'd0, 32'd1);
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic sendString(input string s);
      for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
   endtask

   task automatic startLoad();
      big_log.delete();
      small_log.delete();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait for the big instance to report done, then let a few idle cycles
   // pass so any stray extra write would land in the log.
   task automatic waitDone();
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (big_done) seen = 1'b1;
      end
      if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Expected writes: exp_data[i] at address i, then 0x00 at len(exp_data).
   task automatic checkWrites(input string tag, input bit use_small, input string exp_data);
      int n = exp_data.len();
      int sz = use_small ? small_log.size() : big_log.size();
      logic [15:0] got;
      logic [15:0] want;
      logic [7:0]  ch;
      checkOutput($sformatf("%s_write_count", tag), sz, n + 1);
      for (int i = 0; i <= n; i++) begin
         if (i < sz) got = use_small ? small_log[i] : big_log[i];
         else        got = 16'hxxxx;
         if (i < n) begin
            ch   = exp_data[i];
            want = {8'(i), ch};
         end else begin
            want = {8'(n), 8'h00};
         end
         checkOutput($sformatf("%s_write%0d", tag, i), 32'(got), 32'(want));
      end
   endtask

   typedef struct {
      string name;
      string stream;
      string big_data;
      int    big_len;
      bit    big_ovf;
      string small_data;
      int    small_len;
      bit    small_ovf;
   } load_vec_t;

   load_vec_t vecs[4];
   logic [7:0] opcodes[8];

   initial begin
      vecs[0] = '{"ops3",  "+-.!",   "+-.",   3, 1'b0, "+-.", 3, 1'b0};
      vecs[1] = '{"empty", "!",      "",      0, 1'b0, "",    0, 1'b0};
      vecs[2] = '{"cap",   "++++!",  "++++",  4, 1'b0, "+++", 3, 1'b1};
`ifdef PROG_LOADER_FILTER_EN
      vecs[3] = '{"mixed", "a+ b>!", "+>",    2, 1'b0, "+>",  2, 1'b0};
`else
      vecs[3] = '{"mixed", "a+ b>!", "a+ b>", 5, 1'b0, "a+ ", 3, 1'b1};
`endif
      opcodes = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready",    big_ready,    1'b0);
      checkOutput("rst_wen",      big_wen,      1'b0);
      checkOutput("rst_waddr",    big_waddr,    8'h00);
      checkOutput("rst_wdata",    big_wdata,    8'h00);
      checkOutput("rst_busy",     big_busy,     1'b0);
      checkOutput("rst_done",     big_done,     1'b0);
      checkOutput("rst_prog_len", big_prog_len, 8'h00);
      checkOutput("rst_overflow", big_overflow, 1'b0);
      checkOutput("rst_small_ready", small_ready, 1'b0);
      checkOutput("rst_small_done",  small_done,  1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven whole loads.
      for (int v = 0; v < 4; v++) begin
         startLoad();
         checkOutput({vecs[v].name, "_start_ready"},    big_ready,      1'b1);
         checkOutput({vecs[v].name, "_start_busy"},     big_busy,       1'b1);
         checkOutput({vecs[v].name, "_start_done"},     big_done,       1'b0);
         checkOutput({vecs[v].name, "_start_small_ovf"}, small_overflow, 1'b0);
         sendString(vecs[v].stream);
         waitDone();
         checkOutput({vecs[v].name, "_done"},      big_done,       1'b1);
         checkOutput({vecs[v].name, "_busy"},      big_busy,       1'b0);
         checkOutput({vecs[v].name, "_ready"},     big_ready,      1'b0);
         checkOutput({vecs[v].name, "_prog_len"},  big_prog_len,   8'(vecs[v].big_len));
         checkOutput({vecs[v].name, "_overflow"},  big_overflow,   vecs[v].big_ovf);
         checkOutput({vecs[v].name, "_small_done"}, small_done,    1'b1);
         checkOutput({vecs[v].name, "_small_len"}, small_prog_len, 8'(vecs[v].small_len));
         checkOutput({vecs[v].name, "_small_ovf"}, small_overflow, vecs[v].small_ovf);
         checkWrites(vecs[v].name, 1'b0, vecs[v].big_data);
         checkWrites({vecs[v].name, "_small"}, 1'b1, vecs[v].small_data);
      end

      // start pulsed mid-load must not restart the address counter.
      startLoad();
      applyStimulus(8'h2B);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("midstart_busy", big_busy, 1'b1);
      sendString("-!");
      waitDone();
      checkOutput("midstart_len", big_prog_len, 8'd2);
      checkWrites("midstart", 1'b0, "+-");

      // Sparse valid with random gaps: one write per handshake, next cycle.
      startLoad();
      timing_on = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = opcodes[$urandom_range(0, 7)];
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_data  = 8'h00;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
      repeat (2) @(posedge clk);
      #1;
      timing_on = 1'b0;
      checkOutput("sparse_timing_errs", timing_errs, 0);
      checkOutput("sparse_wen_count",   wen_count,   10);
      checkOutput("sparse_hs_count",    hs_count,    10);
      applyStimulus(8'h21);
      waitDone();
      checkOutput("sparse_prog_len", big_prog_len, 8'd10);

      // Reset in the middle of a load abandons it with no further writes.
      startLoad();
      applyStimulus(8'h2B);
      applyStimulus(8'h2D);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h2B;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("midrst_wen%0d", k),   big_wen,   1'b0);
         checkOutput($sformatf("midrst_ready%0d", k), big_ready, 1'b0);
      end
      checkOutput("midrst_busy",     big_busy,     1'b0);
      checkOutput("midrst_done",     big_done,     1'b0);
      checkOutput("midrst_waddr",    big_waddr,    8'h00);
      checkOutput("midrst_wdata",    big_wdata,    8'h00);
      checkOutput("midrst_prog_len", big_prog_len, 8'h00);
      checkOutput("midrst_overflow", big_overflow, 1'b0);
      checkOutput("midrst_log_size", big_log.size(), 2);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(posedge clk);
      #1;
      startLoad();
      sendString("+!");
      waitDone();
      checkOutput("postrst_len", big_prog_len, 8'd1);
      checkWrites("postrst", 1'b0, "+");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
